// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC-V control path: opcodes, ALU op codes,
// datapath mux selects and the control FSM state set.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Same code set that alu_control decodes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle of control-path signals between the control FSM (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_operation;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
               mem_read, mem_write, reg_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_operation, illegal, retired, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
               mem_read, mem_write, reg_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_operation, illegal, retired, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: sequences ld/sd/beq/R-type through
// fetch..writeback, stalls on mem_ready and counts retired instructions.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctrl
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Outputs depend on state only, except the FETCH IR/PC load and the DECODE illegal flag
    always_comb begin
        state_d            = S_FETCH;
        retired_d          = retired_q;
        ctrl.pc_write      = 1'b0;
        ctrl.pc_write_cond = 1'b0;
        ctrl.pc_source     = 1'b0;
        ctrl.ir_write      = 1'b0;
        ctrl.i_or_d        = 1'b0;
        ctrl.mem_read      = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.reg_write     = 1'b0;
        ctrl.mem_to_reg    = 1'b0;
        ctrl.alu_src_a     = SRCA_PC;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_operation = ALUOP_ADD;
        ctrl.illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = ctrl.mem_ready;
                ctrl.pc_write  = ctrl.mem_ready;
                state_d        = ctrl.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                case (ctrl.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXECUTE;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_REGA;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (ctrl.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = ctrl.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retired_d       = retired_q + 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (ctrl.mem_ready) begin
                    retired_d = retired_q + 1'b1;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_EXECUTE: begin
                ctrl.alu_src_a     = SRCA_REGA;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_operation = ALUOP_FUNCT;
                state_d            = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                retired_d      = retired_q + 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = SRCA_REGA;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_operation = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                retired_d          = retired_q + 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign ctrl.state   = state_q;
    assign ctrl.retired = retired_q;

endmodule
